mcu_ring_ctrl: RTL and testbench
================================

// Module: mcu_ring_ctrl
// PURPOSE
//  Bank-rotation controller for the 2D-conv memory subsystem, parametrised in kernel height and bank count.
//  Treats NBANK line memories as a ring: one bank loads, a KROWS-wide window feeds the convolver, and one bank drains output.
//  Adds to the fixed-size MCU controller: registered phase FSM, illegal-code detection, frame restart,
//  rotating window mask, and window/substate advance on every PROC->OUT exit.
//  Sits between the host-side sequencer (sop/eop/chblk) and the bank write-enable/select muxes.
// PARAMETERS
//  KROWS   3   kernel height = number of banks read concurrently in PROC
//  NBANK   5   banks in ring; must be >= KROWS+2 (elaboration error otherwise)
//  SUB     2   substates per output cycle (KROWS/2+1 for the default)
// PORTS
//  clk           in   1                   clock, rising edge
//  rst           in   1                   asynchronous, active-low reset
//  i_sop         in   1                   phase code bit0
//  i_eop         in   1                   phase code bit1
//  i_chblk       in   1                   block-change level; rising edge is the event
//  i_sof         in   1                   start of frame: synchronous pointer restart
//  o_we          out  NBANK               per-bank enable
//  o_sel         out  $clog2(NBANK)       bank select for the load/out mux
//  o_win_base    out  $clog2(NBANK)       first bank of the PROC window
//  o_state       out  2                   registered phase
//  o_substate    out  $clog2(SUB) (min 1) output substate
//  o_err         out  1                   sticky: illegal phase code seen
// BEHAVIOUR
//  Phase code {i_eop,i_sop}:
//   00 = LOAD, 01 = PROC, 10 = OUT.
//   11 = illegal: state holds and o_err sets.
//  state <= code every cycle, so outputs follow the code with 1-cycle latency.
//  Reset (asynchronous, while rst=0):
//   state=LOAD, load_ptr=KROWS, win_base=0, out_ptr=NBANK-1, substate=0, chblk_q=0, o_err=0.
//   Resulting outputs: o_we=onehot(KROWS), o_sel=KROWS.
//  Edge detect: rise = i_chblk & ~chblk_q; chblk_q <= i_chblk every cycle.
//  The rise event is applied against the registered (current) state, not the incoming code.
//  Per-state pointer updates:
//   LOAD: rise -> load_ptr <= (load_ptr==NBANK-1) ? 0 : load_ptr+1.
//   OUT:  rise -> out_ptr  <= (out_ptr==NBANK-1)  ? 0 : out_ptr+1.
//   PROC: rise is ignored.
//  Transition state==PROC && code==OUT:
//   win_base <= win_base+1 mod NBANK.
//   substate <= (substate==SUB-1) ? 0 : substate+1.
//   Both advance exactly once per transition, never per cycle.
//  Combinational outputs, from registered state and pointers only:
//   LOAD: o_we = onehot(load_ptr); o_sel = load_ptr.
//   PROC: o_we = KROWS ones starting at bit win_base, wrapping past NBANK-1; o_sel = win_base.
//   OUT:  o_we = 0; o_sel = out_ptr.
//  i_sof:
//   Synchronous; highest priority over rise and transitions in the same cycle.
//   Restores all pointers and substate to reset values and clears o_err. state still follows the code.
//  Illegal code in the same cycle as a rise: the rise is ignored and no pointer moves.
//  o_err clears only on rst or i_sof.
//  Reset asserted mid-operation: all registers return to reset values immediately. No pending rise survives.
//  Pointer overlap is not checked in RTL; the verification assertions cover it.
// STRUCTURE
//  Shared package: phase localparams LOAD/PROC/OUT/ILL and the rotating-mask function rotmask(base, KROWS, NBANK).
//  One sub-module: mcu_edge_det (1-bit rising-edge detector, async active-low reset).
//  Everything else stays in this module.
// TESTING (KROWS=3, NBANK=5, SUB=2)
//  1. Reset, code 00 -> o_we=5'b01000, o_sel=3, o_err=0.
//  2. LOAD with 3 chblk rises -> o_sel 4, 0, 1; o_we=5'b00010. A held-high chblk gives no extra step.
//  3. Code 01 -> o_we=5'b00111.
//     Then 10 -> win_base=1, substate=1.
//     Then 01 -> o_we=5'b01110.
//     Repeat until win_base=3 -> o_we=5'b11001 (wrap).
//  4. OUT from reset with 1 rise -> o_sel 4->0. Code 11 for 2 cycles -> state held, o_err=1.
//  5. i_sof together with a rise in LOAD -> load_ptr=3 (not 4) and o_err=0 next cycle.
//  6. rst low mid-PROC with win_base=2 -> immediate reset values; outputs match scenario 1 after release.

Source files
------------

// File: rtl/mcu_ring_ctrl_pkg.sv
// Shared definitions for the bank-rotation controller: phase codes and the
// rotating window-mask helper.
package mcu_ring_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    PROC = 2'b01,
    OUT  = 2'b10,
    ILL  = 2'b11
  } phase_t;

  // KROWS consecutive ones starting at bit base, wrapping at nbank.
  function automatic logic [31:0] rotmask(input int base, input int krows, input int nbank);
    logic [31:0] m;
    int          idx;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < krows) begin
        idx = base + i;
        if (idx >= nbank) idx = idx - nbank;
        m[idx[4:0]] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mcu_ring_ctrl_if.sv
// Sequencer-side and bank-mux-side signals of the ring controller.
interface mcu_ring_ctrl_if #(
  parameter int NBANK = 5,
  parameter int SUB   = 2
);
  localparam int SEL_W = $clog2(NBANK);
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  logic             i_sop;
  logic             i_eop;
  logic             i_chblk;
  logic             i_sof;
  logic [NBANK-1:0] o_we;
  logic [SEL_W-1:0] o_sel;
  logic [SEL_W-1:0] o_win_base;
  logic [1:0]       o_state;
  logic [SUB_W-1:0] o_substate;
  logic             o_err;

  modport master (
    output i_sop, i_eop, i_chblk, i_sof,
    input  o_we, o_sel, o_win_base, o_state, o_substate, o_err
  );

  modport slave (
    input  i_sop, i_eop, i_chblk, i_sof,
    output o_we, o_sel, o_win_base, o_state, o_substate, o_err
  );
endinterface

// File: rtl/mcu_edge_det.sv
// One-bit rising-edge detector; the previous level is kept in a register.
module mcu_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

  assign rise = d & ~q;
endmodule

// File: rtl/mcu_ring_ctrl.sv
// Ring-of-banks controller: one bank loads, a KROWS window feeds the
// convolver, one bank drains; pointers step on block-change edges.
module mcu_ring_ctrl
  import mcu_ring_ctrl_pkg::*;
#(
  parameter int KROWS = 3,
  parameter int NBANK = 5,
  parameter int SUB   = 2
) (
  input  logic           clk,
  input  logic           rst,
  mcu_ring_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(NBANK);
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

  localparam logic [SEL_W-1:0] PTR_LAST  = SEL_W'(NBANK - 1);
  localparam logic [SEL_W-1:0] LOAD_INIT = SEL_W'(KROWS);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUB - 1);

  if (NBANK < KROWS + 2) begin : g_bad_params
    $error("mcu_ring_ctrl: NBANK must be >= KROWS+2");
  end

  phase_t           state;
  logic [SEL_W-1:0] load_ptr;
  logic [SEL_W-1:0] out_ptr;
  logic [SEL_W-1:0] win_base;
  logic [SUB_W-1:0] substate;
  logic             err;
  logic             rise;
  logic [1:0]       code;
  logic             ill;

  assign code = {bus.i_eop, bus.i_sop};
  assign ill  = (code == 2'(ILL));

  mcu_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.i_chblk),
    .rise (rise)
  );

  // Registered phase and pointers; i_sof outranks edges and transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      load_ptr <= LOAD_INIT;
      out_ptr  <= PTR_LAST;
      win_base <= '0;
      substate <= '0;
      err      <= 1'b0;
    end else begin
      if (!ill) state <= phase_t'(code);

      if (bus.i_sof)  err <= 1'b0;
      else if (ill)   err <= 1'b1;

      if (bus.i_sof) begin
        load_ptr <= LOAD_INIT;
        out_ptr  <= PTR_LAST;
        win_base <= '0;
        substate <= '0;
      end else if (!ill) begin
        case (state)
          LOAD: if (rise) load_ptr <= (load_ptr == PTR_LAST) ? '0 : load_ptr + 1'b1;
          OUT:  if (rise) out_ptr  <= (out_ptr  == PTR_LAST) ? '0 : out_ptr + 1'b1;
          PROC: if (code == 2'(OUT)) begin
            win_base <= (win_base == PTR_LAST) ? '0 : win_base + 1'b1;
            substate <= (substate == SUB_LAST) ? '0 : substate + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [31:0]      mask_all;
  logic [NBANK-1:0] we_c;
  logic [SEL_W-1:0] sel_c;
  logic             unused_mask_hi;

  assign mask_all       = rotmask(int'(win_base), KROWS, NBANK);
  assign unused_mask_hi = ^mask_all[31:NBANK];

  always_comb begin
    we_c  = '0;
    sel_c = load_ptr;
    case (state)
      LOAD: begin
        we_c  = NBANK'(1) << load_ptr;
        sel_c = load_ptr;
      end
      PROC: begin
        we_c  = mask_all[NBANK-1:0];
        sel_c = win_base;
      end
      OUT: begin
        we_c  = '0;
        sel_c = out_ptr;
      end
      default: ;
    endcase
  end

  assign bus.o_we       = we_c;
  assign bus.o_sel      = sel_c;
  assign bus.o_win_base = win_base;
  assign bus.o_state    = state;
  assign bus.o_substate = substate;
  assign bus.o_err      = err;
endmodule

// File: tb/tb_mcu_ring_ctrl.sv
// Directed bench for mcu_ring_ctrl with KROWS=3, NBANK=5, SUB=2.
module tb_mcu_ring_ctrl;
  logic clk;
  logic rst;
  int   vecs;
  int   miss;

  mcu_ring_ctrl_if #(.NBANK(5), .SUB(2)) bus ();

  mcu_ring_ctrl #(.KROWS(3), .NBANK(5), .SUB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive code/chblk/sof just after an edge, advance one clock, settle.
  task automatic step(input logic [1:0] code, input logic chblk, input logic sof);
    bus.i_eop   = code[1];
    bus.i_sop   = code[0];
    bus.i_chblk = chblk;
    bus.i_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    rst  = 1'b0;
    bus.i_sop = 1'b0; bus.i_eop = 1'b0; bus.i_chblk = 1'b0; bus.i_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    32'(bus.o_we),       32'b01000);
    chk("rst_sel",   32'(bus.o_sel),      32'd3);
    chk("rst_err",   32'(bus.o_err),      32'd0);
    chk("rst_state", 32'(bus.o_state),    32'd0);
    chk("rst_win",   32'(bus.o_win_base), 32'd0);
    chk("rst_out",   32'(bus.o_substate), 32'd0);
    rst = 1'b1;

    // Scenario 1/2: LOAD and chblk edges
    step(2'b00, 1'b0, 1'b0);
    chk("s1_we",  32'(bus.o_we),  32'b01000);
    chk("s1_sel", 32'(bus.o_sel), 32'd3);
    step(2'b00, 1'b1, 1'b0);
    chk("s2_sel4", 32'(bus.o_sel), 32'd4);
    step(2'b00, 1'b1, 1'b0);
    chk("s2_hold", 32'(bus.o_sel), 32'd4);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("s2_sel0", 32'(bus.o_sel), 32'd0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("s2_sel1", 32'(bus.o_sel), 32'd1);
    chk("s2_we",   32'(bus.o_we),  32'b00010);

    // Scenario 3: window rotation on PROC->OUT exits
    step(2'b01, 1'b0, 1'b0);
    chk("s3_we0",  32'(bus.o_we),  32'b00111);
    chk("s3_sel0", 32'(bus.o_sel), 32'd0);
    step(2'b10, 1'b0, 1'b0);
    chk("s3_win1",  32'(bus.o_win_base), 32'd1);
    chk("s3_sub1",  32'(bus.o_substate), 32'd1);
    chk("s3_outwe", 32'(bus.o_we),       32'b00000);
    chk("s3_outsl", 32'(bus.o_sel),      32'd4);
    step(2'b10, 1'b0, 1'b0);
    chk("s3_once", 32'(bus.o_win_base), 32'd1);
    step(2'b01, 1'b0, 1'b0);
    chk("s3_we1", 32'(bus.o_we), 32'b01110);
    step(2'b10, 1'b0, 1'b0);
    chk("s3_sub0", 32'(bus.o_substate), 32'd0);
    step(2'b01, 1'b0, 1'b0);
    chk("s3_we2", 32'(bus.o_we), 32'b11100);
    step(2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    chk("s3_win3", 32'(bus.o_win_base), 32'd3);
    chk("s3_wrap", 32'(bus.o_we),       32'b11001);
    chk("s3_sel3", 32'(bus.o_sel),      32'd3);

    // Scenario 4: OUT from reset, then illegal code
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(2'b10, 1'b0, 1'b0);
    chk("s4_sel4", 32'(bus.o_sel), 32'd4);
    step(2'b10, 1'b1, 1'b0);
    chk("s4_sel0", 32'(bus.o_sel), 32'd0);
    step(2'b11, 1'b0, 1'b0);
    chk("s4_hold", 32'(bus.o_state), 32'd2);
    chk("s4_err",  32'(bus.o_err),   32'd1);
    step(2'b11, 1'b1, 1'b0);
    chk("s4_illrise", 32'(bus.o_sel),   32'd0);
    chk("s4_hold2",   32'(bus.o_state), 32'd2);
    step(2'b00, 1'b1, 1'b0);
    chk("s4_sticky", 32'(bus.o_err), 32'd1);
    chk("s4_load",   32'(bus.o_sel), 32'd3);

    // Scenario 5: i_sof beats a simultaneous rise
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1);
    chk("s5_sel", 32'(bus.o_sel), 32'd3);
    chk("s5_err", 32'(bus.o_err), 32'd0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("s5_after", 32'(bus.o_sel), 32'd4);

    // Scenario 6: asynchronous reset mid-PROC
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    chk("s6_pre_win", 32'(bus.o_win_base), 32'd2);
    chk("s6_pre_we",  32'(bus.o_we),       32'b11100);
    rst = 1'b0;
    #1;
    chk("s6_we",    32'(bus.o_we),       32'b01000);
    chk("s6_sel",   32'(bus.o_sel),      32'd3);
    chk("s6_win",   32'(bus.o_win_base), 32'd0);
    chk("s6_state", 32'(bus.o_state),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    chk("s6_rel_we",  32'(bus.o_we),  32'b01000);
    chk("s6_rel_sel", 32'(bus.o_sel), 32'd3);
    chk("s6_rel_err", 32'(bus.o_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
